// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_pkg                                                    |
// | State encoding and sizing helpers for the FIFO-to-UART drain.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Serial bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
        return 1 + data_width + ((parity_en != 0) ? 1 : 0) + stop_bits;
    endfunction

    function automatic int cnt_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_tx_if                                                  |
// | FIFO pop handshake plus serial-side outputs of the UART drain.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic                  fifo_val;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_read;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output enable, fifo_val, fifo_data,
        input  fifo_read, tx, busy, frame_done
    );

    modport slave (
        input  enable, fifo_val, fifo_data,
        output fifo_read, tx, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_baud_counter                                                |
// | Per-bit down counter; reloads on request, flags the bit's end.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_baud_counter #(
    parameter int CLK_DIV = 16,
    parameter int CNT_W   = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_load,
    input  wire logic i_run,
    output logic      o_bit_end,
    output logic      o_bit_near_end
);
    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_RELOAD;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_bit_end      = (r_cnt == '0);
    assign o_bit_near_end = (r_cnt == CNT_W'(1));
endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_uart_tx                                                     |
// | Pops words from a ring FIFO and serialises them as UART frames.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input wire logic      clk,
    input wire logic      reset,
    fifo_uart_tx_if.slave bus
);
    localparam int                 c_CNT_W     = cnt_width(CLK_DIV);
    localparam int                 c_BIT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam logic               c_PAR_EN    = (PARITY_EN != 0);
    localparam logic               c_PAR_ODD   = (PARITY_ODD != 0);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_bit_end;
    logic                  w_bit_near_end;
    logic                  w_active;
    logic                  w_final_stop;
    logic                  w_pop;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_active     = (r_state != ST_IDLE);
    assign w_final_stop = (r_state == ST_STOP) && (r_bit_cnt == c_LAST_STOP);
    // Reset gates the pop so the FIFO never loses a word while the drain is held.
    assign w_pop        = !reset && bus.enable && bus.fifo_val &&
                          ((r_state == ST_IDLE) || (w_final_stop && w_bit_end));
    assign w_load       = w_pop || (w_active && w_bit_end);
    assign w_shift_next = r_shift >> 1;

    uart_baud_counter #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (c_CNT_W)
    ) u_baud (
        .clk            (clk),
        .rst            (reset),
        .i_load         (w_load),
        .i_run          (w_active),
        .o_bit_end      (w_bit_end),
        .o_bit_near_end (w_bit_near_end)
    );

    // tx/busy are assigned together with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_final_stop && w_bit_near_end;
            if (w_pop) begin
                r_state   <= ST_START;
                r_shift   <= bus.fifo_data;
                r_parity  <= (^bus.fifo_data) ^ c_PAR_ODD;
                r_bit_cnt <= '0;
                r_tx      <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_active && w_bit_end) begin
                unique case (r_state)
                    ST_START: begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                    ST_DATA: begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
                            if (c_PAR_EN) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                            r_tx      <= w_shift_next[0];
                        end
                    end
                    ST_PARITY: begin
                        r_state   <= ST_STOP;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                    end
                    ST_STOP: begin
                        if (w_final_stop) begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_read  = w_pop;
    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_uart_tx                                                  |
// | Directed checks of framing, parity, back-to-back, enable, reset. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fifo_uart_tx;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // a: plain 8N1, e: even parity, o: odd parity, s: two stop bits; all CLK_DIV=4
    fifo_uart_tx_if #(.DATA_WIDTH(8)) ia ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) ie ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) io ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) is2 ();

    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut_e (.clk(clk), .reset(reset), .bus(ie));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut_o (.clk(clk), .reset(reset), .bus(io));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut_s (.clk(clk), .reset(reset), .bus(is2));

    task automatic test_reset;
        #12;
        checks++;
        if ({ia.tx, ia.busy, ia.fifo_read, ia.frame_done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_a got %b exp 1000", {ia.tx, ia.busy, ia.fifo_read, ia.frame_done});
        end
        checks++;
        if ({ie.tx, ie.busy, io.tx, io.busy, is2.tx, is2.busy} !== 6'b101010) begin
            errors++;
            $display("FAIL reset_others got %b exp 101010", {ie.tx, ie.busy, io.tx, io.busy, is2.tx, is2.busy});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if ({ia.tx, ia.busy, ia.fifo_read} !== 3'b100) begin
                errors++;
                $display("FAIL idle c=%0d got %b exp 100", c, {ia.tx, ia.busy, ia.fifo_read});
            end
        end
    endtask

    task automatic test_single_frame(input logic [7:0] w);
        logic [9:0] fr;
        logic       rd;
        logic       etx;
        fr = {1'b1, w, 1'b0};
        @(posedge clk); #1;
        ia.fifo_data = w;
        ia.fifo_val  = 1'b1;
        for (int c = 0; c <= 44; c++) begin
            @(negedge clk);
            etx = (c >= 1 && c <= 40) ? fr[(c - 1) / 4] : 1'b1;
            checks++;
            if (ia.fifo_read !== (c == 0)) begin
                errors++;
                $display("FAIL single_read c=%0d got %b exp %b", c, ia.fifo_read, (c == 0));
            end
            checks++;
            if (ia.tx !== etx) begin
                errors++;
                $display("FAIL single_tx w=%h c=%0d got %b exp %b", w, c, ia.tx, etx);
            end
            checks++;
            if (ia.busy !== (c >= 1 && c <= 40)) begin
                errors++;
                $display("FAIL single_busy c=%0d got %b exp %b", c, ia.busy, (c >= 1 && c <= 40));
            end
            checks++;
            if (ia.frame_done !== (c == 40)) begin
                errors++;
                $display("FAIL single_done c=%0d got %b exp %b", c, ia.frame_done, (c == 40));
            end
            rd = ia.fifo_read;
            @(posedge clk); #1;
            if (rd) ia.fifo_val = 1'b0;
        end
    endtask

    task automatic test_parity;
        // 8'h07: three ones, so even parity bit is 1 and odd parity bit is 0
        logic [10:0] fe;
        logic [10:0] fo;
        logic        rde;
        logic        rdo;
        logic [1:0]  etx;
        fe = {1'b1, 1'b1, 8'h07, 1'b0};
        fo = {1'b1, 1'b0, 8'h07, 1'b0};
        @(posedge clk); #1;
        ie.fifo_data = 8'h07; ie.fifo_val = 1'b1;
        io.fifo_data = 8'h07; io.fifo_val = 1'b1;
        for (int c = 0; c <= 48; c++) begin
            @(negedge clk);
            etx = (c >= 1 && c <= 44) ? {fe[(c - 1) / 4], fo[(c - 1) / 4]} : 2'b11;
            checks++;
            if ({ie.fifo_read, io.fifo_read} !== {2{c == 0}}) begin
                errors++;
                $display("FAIL parity_read c=%0d got %b", c, {ie.fifo_read, io.fifo_read});
            end
            checks++;
            if ({ie.tx, io.tx} !== etx) begin
                errors++;
                $display("FAIL parity_tx c=%0d got %b exp %b", c, {ie.tx, io.tx}, etx);
            end
            checks++;
            if ({ie.busy, io.busy} !== {2{c >= 1 && c <= 44}}) begin
                errors++;
                $display("FAIL parity_busy c=%0d got %b", c, {ie.busy, io.busy});
            end
            checks++;
            if ({ie.frame_done, io.frame_done} !== {2{c == 44}}) begin
                errors++;
                $display("FAIL parity_done c=%0d got %b", c, {ie.frame_done, io.frame_done});
            end
            rde = ie.fifo_read;
            rdo = io.fifo_read;
            @(posedge clk); #1;
            if (rde) ie.fifo_val = 1'b0;
            if (rdo) io.fifo_val = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  q[$];
        logic [10:0] frs [3];
        logic        rd;
        logic        etx;
        logic        ebusy;
        int          nread;
        q      = '{8'h00, 8'hFF, 8'h3C};
        frs[0] = {2'b11, 8'h00, 1'b0};
        frs[1] = {2'b11, 8'hFF, 1'b0};
        frs[2] = {2'b11, 8'h3C, 1'b0};
        nread  = 0;
        @(posedge clk); #1;
        is2.fifo_data = q[0];
        is2.fifo_val  = 1'b1;
        for (int c = 0; c <= 140; c++) begin
            @(negedge clk);
            ebusy = (c >= 1 && c <= 132);
            etx   = ebusy ? frs[(c - 1) / 44][((c - 1) % 44) / 4] : 1'b1;
            checks++;
            if (is2.fifo_read !== (c == 0 || c == 44 || c == 88)) begin
                errors++;
                $display("FAIL b2b_read c=%0d got %b", c, is2.fifo_read);
            end
            checks++;
            if (is2.tx !== etx) begin
                errors++;
                $display("FAIL b2b_tx c=%0d got %b exp %b", c, is2.tx, etx);
            end
            checks++;
            if (is2.busy !== ebusy) begin
                errors++;
                $display("FAIL b2b_busy c=%0d got %b exp %b", c, is2.busy, ebusy);
            end
            checks++;
            if (is2.frame_done !== (c == 44 || c == 88 || c == 132)) begin
                errors++;
                $display("FAIL b2b_done c=%0d got %b", c, is2.frame_done);
            end
            rd = is2.fifo_read;
            @(posedge clk); #1;
            if (rd) begin
                nread++;
                void'(q.pop_front());
                if (q.size() == 0) is2.fifo_val = 1'b0;
                else is2.fifo_data = q[0];
            end
        end
        checks++;
        if (nread != 3) begin
            errors++;
            $display("FAIL b2b_pops got %0d exp 3", nread);
        end
    endtask

    task automatic test_enable_drop;
        logic [7:0] q[$];
        logic [9:0] f0;
        logic [9:0] f1;
        logic       rd;
        logic       etx;
        logic       ebusy;
        q  = '{8'h5A, 8'hC3};
        f0 = {1'b1, 8'h5A, 1'b0};
        f1 = {1'b1, 8'hC3, 1'b0};
        @(posedge clk); #1;
        ia.fifo_data = q[0];
        ia.fifo_val  = 1'b1;
        for (int c = 0; c <= 115; c++) begin
            @(negedge clk);
            ebusy = (c >= 1 && c <= 40) || (c >= 72 && c <= 111);
            if (c >= 1 && c <= 40) etx = f0[(c - 1) / 4];
            else if (c >= 72 && c <= 111) etx = f1[(c - 72) / 4];
            else etx = 1'b1;
            checks++;
            if (ia.fifo_read !== (c == 0 || c == 71)) begin
                errors++;
                $display("FAIL en_read c=%0d got %b", c, ia.fifo_read);
            end
            checks++;
            if (ia.tx !== etx) begin
                errors++;
                $display("FAIL en_tx c=%0d got %b exp %b", c, ia.tx, etx);
            end
            checks++;
            if (ia.busy !== ebusy) begin
                errors++;
                $display("FAIL en_busy c=%0d got %b exp %b", c, ia.busy, ebusy);
            end
            checks++;
            if (ia.frame_done !== (c == 40 || c == 111)) begin
                errors++;
                $display("FAIL en_done c=%0d got %b", c, ia.frame_done);
            end
            rd = ia.fifo_read;
            @(posedge clk); #1;
            if (c == 16) ia.enable = 1'b0;   // effective from cycle 17 = data bit 3
            if (c == 70) ia.enable = 1'b1;
            if (rd) begin
                void'(q.pop_front());
                if (q.size() == 0) ia.fifo_val = 1'b0;
                else ia.fifo_data = q[0];
            end
        end
    endtask

    task automatic test_async_reset;
        logic rd;
        @(posedge clk); #1;
        ia.fifo_data = 8'hF0;
        ia.fifo_val  = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            rd = ia.fifo_read;
            @(posedge clk); #1;
            if (rd) ia.fifo_val = 1'b0;
        end
        checks++;
        if (ia.busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_busy got %b exp 1", ia.busy);
        end
        ia.fifo_data = 8'h96;
        ia.fifo_val  = 1'b1;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ia.tx, ia.busy, ia.fifo_read, ia.frame_done} !== 4'b1000) begin
            errors++;
            $display("FAIL arst_now got %b exp 1000", {ia.tx, ia.busy, ia.fifo_read, ia.frame_done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        // fresh 8'h96 frame: read in the first cycle, start bit next
        for (int c = 0; c <= 44; c++) begin
            @(negedge clk);
            checks++;
            if (ia.fifo_read !== (c == 0)) begin
                errors++;
                $display("FAIL arst_read c=%0d got %b exp %b", c, ia.fifo_read, (c == 0));
            end
            checks++;
            if (ia.tx !== ((c >= 1 && c <= 40) ? ((c <= 4) ? 1'b0 : ((c <= 36) ? ((8'h96 >> ((c - 5) / 4)) & 8'h01) != 0 : 1'b1)) : 1'b1)) begin
                errors++;
                $display("FAIL arst_tx c=%0d got %b", c, ia.tx);
            end
            rd = ia.fifo_read;
            @(posedge clk); #1;
            if (rd) ia.fifo_val = 1'b0;
        end
    endtask

    initial begin
        ia.enable  = 1'b1; ia.fifo_val  = 1'b0; ia.fifo_data  = 8'h00;
        ie.enable  = 1'b1; ie.fifo_val  = 1'b0; ie.fifo_data  = 8'h00;
        io.enable  = 1'b1; io.fifo_val  = 1'b0; io.fifo_data  = 8'h00;
        is2.enable = 1'b1; is2.fifo_val = 1'b0; is2.fifo_data = 8'h00;
        test_reset();
        test_single_frame(8'hA5);
        test_single_frame(8'h01);
        test_parity();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the team's ring FIFO. It pops one word whenever the FIFO reports valid data and serialises it onto a UART line: start bit, DATA_WIDTH data bits LSB first, an optional parity bit, then 1 or 2 stop bits. Frames go out back-to-back with no idle gap while the FIFO stays non-empty. This is the block that connects the FIFO to an external serial pin.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO data width.
- CLK_DIV, 16, clock cycles per serial bit; must be ≥2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new frame starts; a frame already in flight completes.
- fifo_val  in  1  FIFO non-empty flag.
- fifo_data  in  DATA_WIDTH  FIFO head word, combinational from the FIFO.
- fifo_read  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is being transmitted.
- frame_done  out  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; tx=1; busy=0; frame_done=0; fifo_read=0.
  - Baud counter, bit counter and shift register cleared.
- Reset asserted mid-frame aborts the frame immediately and tx goes to 1. The popped word is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- Baud counter:
  - Loads CLK_DIV-1 on every state entry and counts down.
  - A bit ends in the cycle the counter reads 0. Each bit therefore lasts exactly CLK_DIV cycles.
- fifo_read is combinational: fifo_read = (state==IDLE or last cycle of the final stop bit) & enable & fifo_val.
  - In a fifo_read cycle, fifo_data is latched into the shift register on the same edge.
  - The next state is START.
  - fifo_read is never high for two consecutive cycles.
- tx, busy and frame_done are registered.
  - tx equals the current bit value: START=0, DATA=shift[0], PARITY=p, STOP=1, IDLE=1.
  - busy = (state != IDLE).
- Latency: tx falls on the clock edge at which fifo_read was sampled high, i.e. the cycle after the read strobe.
- DATA state:
  - Shift right at the end of each bit.
  - Bit counter runs 0..DATA_WIDTH-1.
  - After the last data bit, go to PARITY if PARITY_EN, else STOP.
- Parity: p = (XOR of the latched word) XOR PARITY_ODD, computed at latch time.
- STOP state:
  - Lasts STOP_BITS × CLK_DIV cycles.
  - frame_done pulses in its final cycle.
  - In that same cycle, if enable & fifo_val, the next word is popped and the block goes straight to START (zero gap); otherwise it goes to IDLE.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLK_DIV cycles exactly.
- enable deasserted mid-frame: the frame completes and the block returns to IDLE, with no pop.
- fifo_val falling mid-frame has no effect.
- fifo_data is ignored except in a fifo_read cycle.

Decomposition:
- Package fifo_uart_pkg:
  - State encoding constants.
  - Localparams FRAME_BITS = 1+DATA_WIDTH+PARITY_EN+STOP_BITS and CNT_W = $clog2(CLK_DIV).
- One natural sub-module, uart_baud_counter: load/count-down with a bit_end output.
- The FSM, shift register and parity logic stay in the top module.

Test Plan:
- Reset then idle: tx=1, busy=0 and fifo_read=0 for 100 cycles with fifo_val=0.
- Single frame (CLK_DIV=4, no parity, 1 stop), push 8'hA5:
  - fifo_read pulses for exactly 1 cycle.
  - tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles.
  - busy high for 40 cycles; frame_done pulses once at cycle 40.
- Parity: PARITY_EN=1, word 8'h07.
  - Even parity: bit = 1.
  - PARITY_ODD=1: bit = 0.
  - Frame is 44 cycles.
- Back-to-back: 3 words queued (8'h00, 8'hFF, 8'h3C) with STOP_BITS=2.
  - Exactly 3 fifo_read pulses, spaced 44 cycles apart.
  - No idle cycle between frames; all bits correct.
- enable dropped at data bit 3 of the first of two queued words:
  - First frame completes.
  - No second fifo_read until enable returns.
  - tx stays 1 meanwhile.
- Reset asserted mid-DATA, asynchronously between edges:
  - tx=1 and busy=0 immediately.
  - After release with fifo_val=1, a fresh frame starts from START.
